cache_fill_ctrl: RTL and testbench
==================================

// Module: cache_fill_ctrl
// PURPOSE
//  Parametrised cache-miss block-fill controller between the cache tag/data arrays and main memory.
//  On a miss it issues back-to-back pipelined word reads for the whole block, streams the returned
//  words into the data array with word index, and writes the tag once all words are in. It also
//  forwards the requested (critical) word to the pipeline as soon as it returns; fsm_busy stalls.
// PARAMETERS
//  ADDR_W   16  address width (byte addresses)
//  DATA_W   16  memory/cache word width; power-of-2 multiple of 8; BYTES = DATA_W/8
//  WORDS     8  words per cache block; power of 2, >=2; IDX_W = $clog2(WORDS)
//  (derived) OFF_W = $clog2(WORDS*BYTES) block-offset bits; BOFF_W = $clog2(BYTES)
// PORTS
//  clk                in   1       clock, all state on rising edge
//  rst                in   1       synchronous, active-high reset
//  miss_detected      in   1       tag logic reports a miss (level; sampled only in IDLE)
//  miss_address       in   ADDR_W  byte address that missed (sampled with miss_detected)
//  memory_data        in   DATA_W  read data returning from memory
//  memory_data_valid  in   1       memory_data valid this cycle; returns arrive in request order
//  fsm_busy           out  1       high from cycle after miss accept through DONE (pipeline stall)
//  memory_rd          out  1       read request strobe, one word per asserted cycle
//  memory_address     out  ADDR_W  read address, valid when memory_rd=1, else 0
//  write_data_array   out  1       data-array write enable (one per returned word)
//  write_word_idx     out  IDX_W   word slot within block for write_data_array
//  write_data         out  DATA_W  word to write (combinational pass-through of memory_data)
//  write_tag_array    out  1       one-cycle tag/valid write after final word is written
//  miss_data          out  DATA_W  registered critical word; held until next fill captures
//  miss_data_valid    out  1       one-cycle pulse the cycle after critical word is captured
// BEHAVIOUR
//  Reset: state=IDLE, counters=0; every output 0, miss_data=0.
//  Accept (IDLE & miss_detected): latch base = miss_address with low OFF_W bits cleared and
//   crit_idx = miss_address[OFF_W-1:BOFF_W]; issue_cnt=ret_cnt=0; next state ISSUE.
//  ISSUE: memory_rd=1, memory_address = base + issue_cnt*BYTES (no carry into tag bits needed,
//   base aligned); issue_cnt++ each cycle; after WORDS requests (WORDS consecutive cycles) -> DRAIN,
//   or -> DONE directly if the final return arrives in the last ISSUE cycle.
//  Returns counted in ISSUE and DRAIN: on memory_data_valid, write_data_array=1,
//   write_word_idx=ret_cnt, ret_cnt++. If ret_cnt==crit_idx, miss_data<=memory_data and
//   miss_data_valid pulses next cycle (at most once per fill).
//  DRAIN: memory_rd=0; wait for returns; gaps in memory_data_valid of any length tolerated.
//  When the WORDS-th return is written -> DONE. DONE (1 cycle): write_tag_array=1, fsm_busy=1,
//   no data write; then IDLE. fsm_busy=0 in IDLE.
//  Latency (memory latency L cycles, gapless): accept at T, requests T+1..T+WORDS, returns
//   T+1+L..T+WORDS+L, write_tag_array at T+WORDS+L+1, fsm_busy falls at T+WORDS+L+2.
//  Boundaries:
//   - miss_detected while not IDLE: ignored; still-high miss in the IDLE cycle after DONE starts
//     a new fill (tag logic deasserts once the tag is written).
//   - memory_data_valid in IDLE or DONE, or beyond WORDS returns: ignored, no array write.
//   - rst mid-fill: next cycle IDLE, all outputs 0, no write_tag_array; partial block stays tag-
//     invalid; in-flight memory returns after reset ignored (IDLE).
//   - crit_idx = WORDS-1: miss_data_valid pulse coincides with DONE cycle.
//   - counters width IDX_W+1 so issue_cnt/ret_cnt reach WORDS without wrap.
// TESTING (bench memory model, fixed L=4, data = 0xA000 + word index unless stated)
//  1 miss 0x1234, defaults -> memory_address 0x1230,0x1232..0x123E on 8 consecutive cycles;
//    8 write_data_array pulses idx 0..7; write_tag_array 1 cycle after 8th; busy drops next cycle.
//  2 miss 0x123A (crit_idx 5) -> miss_data=0xA005, miss_data_valid one cycle after 6th return,
//    before write_tag_array; miss_data held through next IDLE.
//  3 returns gapped (valid 1-of-3 cycles) -> DRAIN holds, busy stays 1, tag write only after
//    8th return; extra valid beats in IDLE -> no write_data_array.
//  4 rst asserted after 3 returns -> next cycle all outputs 0, no tag write; new miss 0x2000
//    restarts at 0x2000, idx 0.
//  5 miss_detected held high across fill -> no re-accept mid-fill; second fill begins in the
//    IDLE cycle after DONE.
//  6 WORDS=4, DATA_W=32: miss 0x0107 -> addresses 0x0100,0x0104,0x0108,0x010C; crit_idx 1.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Cache-miss block-fill controller: issues pipelined word reads for a whole block,
// streams returns into the data array, forwards the critical word, then writes the tag.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_detected,
    input  logic [ADDR_W-1:0]          miss_address,
    input  logic [DATA_W-1:0]          memory_data,
    input  logic                       memory_data_valid,
    output logic                       fsm_busy,
    output logic                       memory_rd,
    output logic [ADDR_W-1:0]          memory_address,
    output logic                       write_data_array,
    output logic [$clog2(WORDS)-1:0]   write_word_idx,
    output logic [DATA_W-1:0]          write_data,
    output logic                       write_tag_array,
    output logic [DATA_W-1:0]          miss_data,
    output logic                       miss_data_valid
);

    localparam int BYTES  = DATA_W / 8;
    localparam int IDX_W  = $clog2(WORDS);
    localparam int OFF_W  = $clog2(WORDS * BYTES);
    localparam int BOFF_W = $clog2(BYTES);
    localparam int CNT_W  = IDX_W + 1;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  crit_idx;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic              ret_accept;
    logic              last_ret;

    // Returns only count while a fill is outstanding and the block is not yet full.
    assign ret_accept = ((state == S_ISSUE) || (state == S_DRAIN)) && memory_data_valid
                        && (ret_cnt < CNT_W'(WORDS));
    assign last_ret   = ret_accept && (ret_cnt == CNT_W'(WORDS - 1));

    assign fsm_busy         = (state != S_IDLE);
    assign memory_rd        = (state == S_ISSUE);
    assign write_data_array = ret_accept;
    assign write_word_idx   = ret_cnt[IDX_W-1:0];
    assign write_data       = memory_data;
    assign write_tag_array  = (state == S_DONE);

    always_comb begin
        memory_address = '0;
        if (state == S_ISSUE) begin
            memory_address = base + (ADDR_W'(issue_cnt) << BOFF_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            base            <= '0;
            crit_idx        <= '0;
            issue_cnt       <= '0;
            ret_cnt         <= '0;
            miss_data       <= '0;
            miss_data_valid <= 1'b0;
        end else begin
            miss_data_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (miss_detected) begin
                        base      <= miss_address & ~OFF_MASK;
                        crit_idx  <= miss_address[OFF_W-1:BOFF_W];
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    issue_cnt <= issue_cnt + 1'b1;
                    // The final return can land in the last issue cycle only with zero latency.
                    if (issue_cnt == CNT_W'(WORDS - 1)) begin
                        state <= last_ret ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_ret) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (ret_accept) begin
                ret_cnt <= ret_cnt + 1'b1;
                if (ret_cnt[IDX_W-1:0] == crit_idx) begin
                    miss_data       <= memory_data;
                    miss_data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a latency-4 memory model drives the default instance,
// a second WORDS=4/DATA_W=32 instance is driven by hand.
module tb_cache_fill_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_rd;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  write_word_idx;
    logic [15:0] write_data;
    logic        write_tag_array;
    logic [15:0] miss_data;
    logic        miss_data_valid;

    logic        w4_miss;
    logic [15:0] w4_addr;
    logic [31:0] w4_mdata;
    logic        w4_valid;
    logic        w4_busy;
    logic        w4_rd;
    logic [15:0] w4_maddr;
    logic        w4_wr;
    logic [1:0]  w4_widx;
    logic [31:0] w4_wdata;
    logic        w4_tag;
    logic [31:0] w4_mdat;
    logic        w4_mdv;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data(memory_data), .memory_data_valid(memory_data_valid),
        .fsm_busy(fsm_busy), .memory_rd(memory_rd), .memory_address(memory_address),
        .write_data_array(write_data_array), .write_word_idx(write_word_idx),
        .write_data(write_data), .write_tag_array(write_tag_array),
        .miss_data(miss_data), .miss_data_valid(miss_data_valid)
    );

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .miss_detected(w4_miss), .miss_address(w4_addr),
        .memory_data(w4_mdata), .memory_data_valid(w4_valid),
        .fsm_busy(w4_busy), .memory_rd(w4_rd), .memory_address(w4_maddr),
        .write_data_array(w4_wr), .write_word_idx(w4_widx),
        .write_data(w4_wdata), .write_tag_array(w4_tag),
        .miss_data(w4_mdat), .miss_data_valid(w4_mdv)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    // Memory model state: outstanding requests and when each becomes returnable.
    logic [15:0] q_addr[$];
    int          q_ready[$];
    logic        presenting = 1'b0;
    logic        gap_mode   = 1'b0;
    logic        extra_valid = 1'b0;

    // Per-fill observation logs.
    logic [15:0] addr_log[$];
    int          widx_log[$];
    logic [15:0] wdata_log[$];
    int          wcyc_log[$];
    int          first_rd_cyc, tag_cnt, tag_cyc, mdv_cnt, mdv_cyc, busy_cnt, last_busy_cyc;
    logic [15:0] mdv_data;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        addr_log.delete(); widx_log.delete(); wdata_log.delete(); wcyc_log.delete();
        first_rd_cyc = -1; tag_cnt = 0; tag_cyc = -1; mdv_cnt = 0; mdv_cyc = -1;
        busy_cnt = 0; last_busy_cyc = -1; mdv_data = '0;
    endtask

    // Advance one clock: consume the presented beat, run the memory model, then log outputs.
    task automatic cycle();
        logic [15:0] a;
        @(posedge clk);
        #1;
        cyc++;
        if (presenting) begin
            q_addr.delete(0);
            q_ready.delete(0);
        end
        if (memory_rd) begin
            q_addr.push_back(memory_address);
            q_ready.push_back(cyc + 4);
        end
        presenting        = 1'b0;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        if (extra_valid) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hBEEF;
        end else if (q_addr.size() > 0 && q_ready[0] <= cyc && (!gap_mode || (cyc % 3 == 0))) begin
            a                 = q_addr[0];
            presenting        = 1'b1;
            memory_data_valid = 1'b1;
            memory_data       = 16'hA000 + 16'(a[3:1]);
        end
        #1;
        if (memory_rd) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            addr_log.push_back(memory_address);
        end
        if (write_data_array) begin
            widx_log.push_back(int'(write_word_idx));
            wdata_log.push_back(write_data);
            wcyc_log.push_back(cyc);
        end
        if (write_tag_array) begin
            tag_cnt++;
            tag_cyc = cyc;
        end
        if (miss_data_valid) begin
            mdv_cnt++;
            mdv_cyc  = cyc;
            mdv_data = miss_data;
        end
        if (fsm_busy) begin
            busy_cnt++;
            last_busy_cyc = cyc;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr);
        miss_detected = 1'b1;
        miss_address  = addr;
        cycle();
        miss_detected = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (fsm_busy && n < budget) begin
            cycle();
            n++;
        end
        checkOutput("idle_timeout", {31'd0, fsm_busy}, 32'd0);
    endtask

    initial begin
        int t0;
        int n;
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
        memory_data = '0; memory_data_valid = 1'b0;
        w4_miss = 1'b0; w4_addr = '0; w4_mdata = '0; w4_valid = 1'b0;
        clearLogs();
        cycle();
        cycle();
        checkOutput("rst_busy", {31'd0, fsm_busy}, 32'd0);
        checkOutput("rst_rd", {31'd0, memory_rd}, 32'd0);
        checkOutput("rst_addr", {16'd0, memory_address}, 32'd0);
        checkOutput("rst_tag", {31'd0, write_tag_array}, 32'd0);
        checkOutput("rst_mdata", {16'd0, miss_data}, 32'd0);
        checkOutput("rst_w4_busy", {31'd0, w4_busy}, 32'd0);
        checkOutput("rst_w4_mdata", w4_mdat, 32'd0);
        rst = 1'b0;
        cycle();

        $display("[TB] test 1: basic fill 0x1234");
        clearLogs();
        applyStimulus(16'h1234);
        t0 = cyc - 1;
        waitIdle(40);
        checkOutput("t1_nreq", addr_log.size(), 8);
        checkOutput("t1_first_rd", first_rd_cyc, t0 + 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t1_addr%0d", i), {16'd0, addr_log[i]}, 32'h1230 + 2 * i);
            checkOutput($sformatf("t1_idx%0d", i), widx_log[i], i);
        end
        checkOutput("t1_wdata4", {16'd0, wdata_log[4]}, 32'hA004);
        checkOutput("t1_last_write", wcyc_log[7], t0 + 12);
        checkOutput("t1_tag_cnt", tag_cnt, 1);
        checkOutput("t1_tag_cyc", tag_cyc, t0 + 13);
        checkOutput("t1_busy_last", last_busy_cyc, t0 + 13);
        checkOutput("t1_busy_cnt", busy_cnt, 13);
        checkOutput("t1_crit_data", {16'd0, mdv_data}, 32'hA002);
        checkOutput("t1_crit_cyc", mdv_cyc, t0 + 8);

        $display("[TB] test 2: critical word 5");
        clearLogs();
        applyStimulus(16'h123A);
        t0 = cyc - 1;
        waitIdle(40);
        checkOutput("t2_crit_data", {16'd0, mdv_data}, 32'hA005);
        checkOutput("t2_crit_cnt", mdv_cnt, 1);
        checkOutput("t2_crit_cyc", mdv_cyc, t0 + 11);
        checkOutput("t2_tag_cyc", tag_cyc, t0 + 13);
        cycle(); cycle(); cycle();
        checkOutput("t2_hold_data", {16'd0, miss_data}, 32'hA005);
        checkOutput("t2_hold_valid", {31'd0, miss_data_valid}, 32'd0);

        $display("[TB] test 3: gapped returns");
        clearLogs();
        gap_mode = 1'b1;
        applyStimulus(16'h1230);
        t0 = cyc - 1;
        waitIdle(120);
        gap_mode = 1'b0;
        checkOutput("t3_nwrite", widx_log.size(), 8);
        checkOutput("t3_idx7", widx_log[7], 7);
        checkOutput("t3_tag_cnt", tag_cnt, 1);
        checkOutput("t3_tag_after_last", tag_cyc, wcyc_log[7] + 1);
        checkOutput("t3_busy_cnt", busy_cnt, tag_cyc - t0);
        checkOutput("t3_stretched", {31'd0, tag_cyc > t0 + 13}, 32'd1);
        clearLogs();
        extra_valid = 1'b1;
        cycle(); cycle(); cycle();
        extra_valid = 1'b0;
        checkOutput("t3_idle_writes", widx_log.size(), 0);

        $display("[TB] test 4: reset mid-fill");
        clearLogs();
        applyStimulus(16'h1230);
        n = 0;
        while (widx_log.size() < 3 && n < 20) begin
            cycle();
            n++;
        end
        checkOutput("t4_three_returns", widx_log.size(), 3);
        rst = 1'b1;
        cycle();
        checkOutput("t4_busy", {31'd0, fsm_busy}, 32'd0);
        checkOutput("t4_rd", {31'd0, memory_rd}, 32'd0);
        checkOutput("t4_addr", {16'd0, memory_address}, 32'd0);
        checkOutput("t4_wr", {31'd0, write_data_array}, 32'd0);
        checkOutput("t4_tag", {31'd0, write_tag_array}, 32'd0);
        checkOutput("t4_mdata", {16'd0, miss_data}, 32'd0);
        rst = 1'b0;
        clearLogs();
        n = 0;
        while (q_addr.size() > 0 && n < 30) begin
            cycle();
            n++;
        end
        checkOutput("t4_stale_writes", widx_log.size(), 0);
        checkOutput("t4_stale_tag", tag_cnt, 0);
        clearLogs();
        applyStimulus(16'h2000);
        waitIdle(40);
        checkOutput("t4_new_addr0", {16'd0, addr_log[0]}, 32'h2000);
        checkOutput("t4_new_idx0", widx_log[0], 0);
        checkOutput("t4_new_nwrite", widx_log.size(), 8);
        checkOutput("t4_new_data0", {16'd0, wdata_log[0]}, 32'hA000);
        checkOutput("t4_new_tag", tag_cnt, 1);

        $display("[TB] test 5: miss held high");
        clearLogs();
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        cycle();
        t0 = cyc - 1;
        n = 0;
        while (tag_cnt == 0 && n < 40) begin
            cycle();
            n++;
        end
        checkOutput("t5_done_cyc", cyc, t0 + 13);
        checkOutput("t5_no_reaccept", addr_log.size(), 8);
        cycle();
        checkOutput("t5_idle_gap", {31'd0, fsm_busy}, 32'd0);
        cycle();
        checkOutput("t5_second_busy", {31'd0, fsm_busy}, 32'd1);
        checkOutput("t5_second_rd", {31'd0, memory_rd}, 32'd1);
        checkOutput("t5_second_addr", {16'd0, memory_address}, 32'h1230);
        miss_detected = 1'b0;
        waitIdle(40);

        $display("[TB] test 6: WORDS=4 DATA_W=32");
        n = 0;
        while (q_addr.size() > 0 && n < 30) begin
            cycle();
            n++;
        end
        w4_miss = 1'b1;
        w4_addr = 16'h0107;
        cycle();
        w4_miss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t6_rd%0d", i), {31'd0, w4_rd}, 32'd1);
            checkOutput($sformatf("t6_addr%0d", i), {16'd0, w4_maddr}, 32'h0100 + 4 * i);
            cycle();
        end
        checkOutput("t6_drain_busy", {31'd0, w4_busy}, 32'd1);
        checkOutput("t6_drain_rd", {31'd0, w4_rd}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            w4_valid = 1'b1;
            w4_mdata = 32'hA000 + i;
            #1;
            checkOutput($sformatf("t6_wr%0d", i), {31'd0, w4_wr}, 32'd1);
            checkOutput($sformatf("t6_widx%0d", i), {30'd0, w4_widx}, i);
            checkOutput($sformatf("t6_wdata%0d", i), w4_wdata, 32'hA000 + i);
            if (i == 2) checkOutput("t6_mdv", {31'd0, w4_mdv}, 32'd1);
            cycle();
        end
        w4_valid = 1'b0;
        #1;
        checkOutput("t6_tag", {31'd0, w4_tag}, 32'd1);
        checkOutput("t6_done_wr", {31'd0, w4_wr}, 32'd0);
        checkOutput("t6_crit", w4_mdat, 32'hA001);
        cycle();
        checkOutput("t6_idle", {31'd0, w4_busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
